// File: rtl/dec_2outof5_serial.sv
// dec_2outof5_serial
// Serial 2-out-of-5 (weights 7-4-2-1-0) to packed-BCD decoder. Codeword bits
// arrive MSB (weight 7) first. Each 5-bit codeword is checked for exactly two
// ones and decoded to a BCD nibble. DIGITS nibbles are assembled into one
// packed word. The word is then held for a valid/ready handshake.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid_i in_bit_i carries a bit this cycle
//   in_bit_i   serial codeword bit
//   in_first_i marks bit 4 of digit 0 of a new frame
//   in_ready_o decoder accepts a bit (low only while holding a result)
//   out_valid_o frame result valid
//   out_ready_i downstream accepts the result
//   bcd_out_o  packed BCD, first received digit in the top nibble
//   err_mask_o per-digit invalid flag, first digit in the MSB
//   frame_err_o OR of err_mask_o
//   resync_o   one-cycle pulse when a partial frame was discarded
module dec_2outof5_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  input  logic                in_bit_i,
  input  logic                in_first_i,
  output logic                in_ready_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [4*DIGITS-1:0] bcd_out_o,
  output logic [DIGITS-1:0]   err_mask_o,
  output logic                frame_err_o,
  output logic                resync_o
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST_DIG = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]       dig_cnt_q, dig_cnt_d;
  logic [3:0]          shreg_q, shreg_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   err_q, err_d;
  logic                resync_q, resync_d;

  logic                accept;
  logic [4:0]          dec;

  // Returns {invalid, nibble}. The weighted sum of a 2-of-5 codeword gives the
  // digit directly, except that 7+4=11 encodes zero.
  function automatic logic [4:0] decode_cw(input logic [4:0] c);
    logic [2:0] ones;
    logic [3:0] sum;
    ones = 3'(c[4]) + 3'(c[3]) + 3'(c[2]) + 3'(c[1]) + 3'(c[0]);
    sum  = (c[4] ? 4'd7 : 4'd0) + (c[3] ? 4'd4 : 4'd0) + {2'b00, c[2], c[1]};
    if (ones != 3'd2) begin
      return {1'b1, 4'hF};
    end
    if (sum == 4'd11) begin
      return 5'd0;
    end
    return {1'b0, sum};
  endfunction

  assign accept = in_valid_i && (state_q != HOLD);
  assign dec    = decode_cw({shreg_q, in_bit_i});

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      dig_cnt_q <= '0;
      shreg_q   <= '0;
      bcd_q     <= '0;
      err_q     <= '0;
      resync_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dig_cnt_q <= dig_cnt_d;
      shreg_q   <= shreg_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      resync_q  <= resync_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dig_cnt_d = dig_cnt_q;
    shreg_d   = shreg_q;
    bcd_d     = bcd_q;
    err_d     = err_q;
    resync_d  = 1'b0;

    if (accept && in_first_i) begin
      // Start of a frame; in SHIFT this abandons whatever was collected so far.
      resync_d  = (state_q == SHIFT) && ((bit_cnt_q != 3'd0) || (dig_cnt_q != '0));
      state_d   = SHIFT;
      bit_cnt_d = 3'd1;
      dig_cnt_d = '0;
      shreg_d   = {3'b000, in_bit_i};
      bcd_d     = '0;
      err_d     = '0;
    end else if (accept && (state_q == SHIFT)) begin
      if (bit_cnt_q == 3'd4) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (CW'(k) == dig_cnt_q) begin
            bcd_d[4*(DIGITS-1-k) +: 4] = dec[3:0];
            err_d[DIGITS-1-k]          = dec[4];
          end
        end
        bit_cnt_d = 3'd0;
        dig_cnt_d = dig_cnt_q + 1'b1;
        if (dig_cnt_q == LAST_DIG) begin
          state_d = HOLD;
        end
      end else begin
        shreg_d   = {shreg_q[2:0], in_bit_i};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else if ((state_q == HOLD) && out_ready_i) begin
      state_d   = IDLE;
      dig_cnt_d = '0;
    end
  end

  // Outputs
  always_comb begin
    in_ready_o  = (state_q != HOLD);
    out_valid_o = (state_q == HOLD);
  end

  assign bcd_out_o   = bcd_q;
  assign err_mask_o  = err_q;
  assign frame_err_o = |err_q;
  assign resync_o    = resync_q;

endmodule

// File: tb/tb_dec_2outof5_serial.sv
// Self-checking bench for dec_2outof5_serial: directed scenarios with literal
// expectations plus randomized frames, all tracked by a queue-based model.
module tb_dec_2outof5_serial;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, in_first = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, frame_err, resync;
  logic [4*D-1:0] bcd_out;
  logic [D-1:0]   err_mask;

  int errors = 0;
  int checks = 0;
  int rs_cnt = 0;
  bit chk_en = 1'b0;
  bit rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  dec_2outof5_serial #(.DIGITS(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_bit_i    (in_bit),
    .in_first_i  (in_first),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .bcd_out_o   (bcd_out),
    .err_mask_o  (err_mask),
    .frame_err_o (frame_err),
    .resync_o    (resync)
  );

  // Codeword table indexed by digit value.
  logic [4:0] code_tab [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

  function automatic logic [4:0] m_decode(input logic [4:0] c);
    for (int d = 0; d < 10; d++) begin
      if (code_tab[d] == c) return {1'b0, 4'(d)};
    end
    return {1'b1, 4'hF};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = waiting for a frame start, 1 = collecting,
  // 2 = result held. Accepted bits of the current frame live in a queue.
  int             m_mode = 0;
  bit             m_q[$];
  logic [4*D-1:0] m_bcd = '0;
  logic [D-1:0]   m_err = '0;
  logic           m_rs = 1'b0;

  always @(posedge clk) begin
    m_rs = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
      m_q.delete();
      m_bcd = '0;
      m_err = '0;
    end else if (m_mode == 2) begin
      if (out_ready) m_mode = 0;
    end else if (in_valid) begin
      if (in_first) begin
        m_rs = (m_mode == 1);
        m_q.delete();
        m_q.push_back(in_bit);
        m_mode = 1;
        m_bcd = '0;
        m_err = '0;
      end else if (m_mode == 1) begin
        m_q.push_back(in_bit);
        if (m_q.size() % 5 == 0) begin
          int k;
          logic [4:0] c;
          logic [4:0] r;
          k = m_q.size() / 5 - 1;
          for (int j = 0; j < 5; j++) c[4-j] = m_q[5*k+j];
          r = m_decode(c);
          m_bcd[4*(D-1-k) +: 4] = r[3:0];
          m_err[D-1-k] = r[4];
          if (k == D - 1) m_mode = 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (resync === 1'b1) rs_cnt++;
      chk("out_valid", 32'(out_valid), 32'(m_mode == 2));
      chk("in_ready", 32'(in_ready), 32'(m_mode != 2));
      chk("resync", 32'(resync), 32'(m_rs));
      if (m_mode == 2) begin
        chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
        chk("err_mask", 32'(err_mask), 32'(m_err));
        chk("frame_err", 32'(frame_err), 32'(|m_err));
      end
    end
  end

  task automatic send_bit(input logic v, input logic b, input logic f);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    in_first = f;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    send_bit(1'b0, 1'b0, 1'b0);
  endtask

  // Sends the first nbits of a frame (in_first on bit 0), optionally with
  // random in_valid=0 gaps carrying junk, then one idle cycle.
  task automatic send_frame(input logic [19:0] bits, input int gap_pct, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
        send_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      send_bit(1'b1, bits[19-i], (i == 0));
    end
    idle_cycle();
  endtask

  task automatic expect_hold(input string name, input logic [15:0] bcd, input logic [3:0] err);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_bcd"}, 32'(bcd_out), 32'(bcd));
    chk({name, "_err"}, 32'(err_mask), 32'(err));
    chk({name, "_ferr"}, 32'(frame_err), 32'(|err));
  endtask

  // One handshake cycle; the input bit offered during it must be ignored.
  task automatic handshake(input logic v, input logic f);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = v;
    in_bit    = 1'b1;
    in_first  = f;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    chk("post_hs_ready", 32'(in_ready), 32'd1);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int rs0;
    logic [19:0] fr;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_err", 32'(err_mask), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_resync", 32'(resync), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Basic frame, contiguous.
    send_frame(20'b00011_10100_10001_11000, 0, 20);
    expect_hold("f1970", 16'h1970, 4'b0000);
    handshake(1'b0, 1'b0);

    // Invalid digit 1.
    send_frame(20'b00011_11100_10001_11000, 0, 20);
    expect_hold("f1F70", 16'h1F70, 4'b0100);

    // Backpressure: bits offered while holding are not consumed.
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b1, 1'($urandom_range(0, 1)), (i == 2));
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_bcd", 32'(bcd_out), 32'h1F70);
    end
    handshake(1'b1, 1'b1);
    send_frame(20'b01100_01001_00101_00110, 0, 20);
    expect_hold("f6423", 16'h6423, 4'b0000);
    handshake(1'b0, 1'b0);

    // Resync after 7 bits of a partial frame.
    rs0 = rs_cnt;
    send_frame(20'b00011_10100_10001_11000, 0, 7);
    send_frame(20'b10010_10010_10010_10010, 0, 20);
    expect_hold("f8888", 16'h8888, 4'b0000);
    chk("resync_pulses", 32'(rs_cnt - rs0), 32'd1);
    handshake(1'b0, 1'b0);

    // Stray bits in IDLE are dropped.
    for (int i = 0; i < 9; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    idle_cycle();
    chk("stray_valid", 32'(out_valid), 32'd0);
    send_frame(20'b00011_10100_10001_11000, 0, 20);
    expect_hold("stray_1970", 16'h1970, 4'b0000);
    handshake(1'b0, 1'b0);

    // Reset in the middle of digit 2.
    rs0 = rs_cnt;
    send_frame(20'b00011_10100_10001_11000, 0, 12);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_bcd", 32'(bcd_out), 32'd0);
    chk("mrst_err", 32'(err_mask), 32'd0);
    chk("mrst_resync", 32'(resync), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd1);
    send_frame(20'b11000_11000_11000_11000, 0, 20);
    expect_hold("f0000", 16'h0000, 4'b0000);
    chk("mrst_no_resync", 32'(rs_cnt - rs0), 32'd0);
    handshake(1'b0, 1'b0);

    // Randomized frames: mostly valid codewords, gaps, aborts, stray bits,
    // random downstream readiness. The model checks every cycle.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 60; n++) begin
      for (int d = 0; d < 4; d++) begin
        if ($urandom_range(0, 9) < 7) fr[19-5*d -: 5] = code_tab[$urandom_range(0, 9)];
        else fr[19-5*d -: 5] = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 5) == 0)
        repeat ($urandom_range(1, 6)) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 7) == 0) send_frame(fr, 20, $urandom_range(1, 19));
      else send_frame(fr, 20, 20);
      repeat ($urandom_range(0, 6)) idle_cycle();
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (3) idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dec_2outof5_serial.md
# dec_2outof5_serial

Serial 2-out-of-5 (weights 7-4-2-1-0) to packed-BCD decoder: the receive side of the BCD→2-out-of-5 encoding path. It accepts a bit stream of 5-bit codewords, checks each codeword for exactly two ones, and decodes it to a BCD digit. It assembles DIGITS digits into one packed-BCD word and hands that word downstream over a valid/ready handshake.

## Interface
- DIGITS, 4, decimal digits per frame (≥1); bcd_out width is 4*DIGITS.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial codeword bit, codeword bit 4 (weight 7) first, bit 0 (weight 0) last.
- in_first  in  1  qualifies in_bit as bit 4 of digit 0 of a new frame.
- in_ready  out  1  decoder accepts a bit this cycle; 1 in every state except HOLD.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- bcd_out  out  4*DIGITS  packed BCD; first received digit in the top nibble.
- err_mask  out  DIGITS  bit k set if digit k (k=0 first received, maps to err_mask[DIGITS-1-k]) was invalid.
- frame_err  out  1  OR of err_mask.
- resync  out  1  one-cycle pulse: a partial frame was discarded.

## Operation
- A bit is accepted when in_valid && in_ready.
- States: IDLE, SHIFT, HOLD.
  - IDLE: accepted bits without in_first are dropped. An accepted bit with in_first enters SHIFT with bit_cnt=1 and dig_cnt=0.
  - SHIFT: accepted bits are shifted into a 5-bit register. When the 5th bit is accepted, the codeword is decoded and written to its nibble, and dig_cnt is incremented. If it was the last digit, the state moves to HOLD.
  - HOLD: out_valid=1 and outputs are stable. When out_valid && out_ready, the state returns to IDLE. in_ready=0 in HOLD.
- Decode, codeword bits 4..0 → digit:
  - 11000→0, 00011→1, 00101→2, 00110→3, 01001→4, 01010→5, 01100→6, 10001→7, 10010→8, 10100→9.
  - Any popcount≠2 is invalid: the nibble is written as 4'hF and the matching err_mask bit is set.
- Resync: in_first accepted in SHIFT with bit_cnt≠0 or dig_cnt≠0 discards the partial frame, clears err_mask and bcd_out, pulses resync, and treats the bit as bit 4 of digit 0.
- in_first on the 1st bit of digit 0 is normal. in_first on any other bit position counts as a resync.
- in_first while in HOLD is not accepted, because in_ready=0.
- err_mask and bcd_out are cleared on entry to SHIFT from IDLE.

## Timing
- Reset, at the clk edge with rst_n=0:
  - state=IDLE; out_valid=0, bcd_out=0, err_mask=0, frame_err=0, resync=0; counters=0.
  - in_ready=1 from the first cycle after that edge.
- rst_n low mid-frame or in HOLD: the partial/held result is discarded, no resync pulse.
- Latency: last bit accepted at edge N → out_valid=1 and bcd_out valid after edge N (the cycle following).
- out_valid stays high with stable bcd_out/err_mask until the handshake.
- in_ready=1 in the cycle after the handshake edge.
- No bit is accepted in the handshake cycle.
- resync is high for exactly the cycle after the edge that accepted the resyncing bit.
- in_valid=0 gaps of any length inside a frame are allowed and change nothing.
- Counters: bit_cnt wraps 4→0 per digit; dig_cnt reaches DIGITS, then clears in HOLD.

## Test plan
- DIGITS=4, frame 00011 10100 10001 11000 (in_first on the first bit), contiguous → one cycle after the 20th bit: out_valid=1, bcd_out=16'h1970, err_mask=0, frame_err=0.
- Same frame with digit 1 replaced by 11100 → bcd_out=16'h1F70, err_mask=4'b0100, frame_err=1.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 → in_ready=0, bcd_out stable, no bits consumed. out_ready=1 → IDLE, then a new frame 01100 01001 00101 00110 decodes to 16'h6423.
- Resync: 7 bits of a frame, then in_first with 10010 10010 10010 10010 → resync pulses once, result 16'h8888, err_mask=0.
- Stray bits: 9 accepted bits with in_first=0 in IDLE → no state change. A following valid frame decodes correctly.
- Reset: rst_n=0 for 1 cycle mid-frame (at digit 2) → all outputs 0, in_ready=1. A later full frame of 11000×4 → 16'h0000, err_mask=0.
